// File: rtl/wrr_rank_calc_pipe_pkg.sv
// Shared widths, state/result layouts and small helpers for the pipelined WRR rank calculator.
// Serial numbers are {epoch, round}; comparing them modulo 2^(E+R) tolerates wraparound.
package wrr_pkg;

  localparam int NUM_PHY_PORTS   = 4;
  localparam int NUM_PORTS       = NUM_PHY_PORTS + 1;
  localparam int PORT_INFO_WIDTH = 2 * NUM_PHY_PORTS;
  localparam int PORT_ID_WIDTH   = 3;
  localparam int CLASS_WIDTH     = 5;
  localparam int ROUND_WIDTH     = 11;
  localparam int EPOCH_WIDTH     = 2;
  localparam int CREDIT_WIDTH    = 8;
  localparam int PIFO_INFO_WIDTH = 12;
  localparam int SERIAL_WIDTH    = EPOCH_WIDTH + ROUND_WIDTH;
  localparam int RESULT_WIDTH    = 1 + CLASS_WIDTH + SERIAL_WIDTH + PIFO_INFO_WIDTH;
  localparam int ID_WIDTH        = PORT_ID_WIDTH + CLASS_WIDTH;
  localparam int RAM_DEPTH       = NUM_PORTS << CLASS_WIDTH;
  localparam int IN_DATA_WIDTH   = PORT_INFO_WIDTH + CLASS_WIDTH;
  localparam int CPU_VAL_WIDTH   = SERIAL_WIDTH + 2 * CREDIT_WIDTH;

  typedef logic [SERIAL_WIDTH-1:0] serial_t;

  typedef struct packed {
    logic [EPOCH_WIDTH-1:0] epoch;
    logic [ROUND_WIDTH-1:0] round;
  } rank_t;

  typedef struct packed {
    rank_t                   rank;
    logic [CREDIT_WIDTH-1:0] credit;
  } state_t;

  typedef struct packed {
    logic                       valid;
    logic [CLASS_WIDTH-1:0]     cls;
    rank_t                      rank;
    logic [PIFO_INFO_WIDTH-1:0] pifo_info;
  } result_t;

  // Only a single set bit at an even position names a physical port; everything else is CPU/DMA.
  function automatic logic [PORT_ID_WIDTH-1:0] decode_port(input logic [PORT_INFO_WIDTH-1:0] info);
    logic [PORT_ID_WIDTH-1:0] id;
    id = PORT_ID_WIDTH'(NUM_PHY_PORTS);
    for (int k = 0; k < NUM_PHY_PORTS; k++) begin
      if (info == (PORT_INFO_WIDTH'(1) << (2 * k))) id = PORT_ID_WIDTH'(k);
    end
    return id;
  endfunction

  function automatic logic is_stale(input serial_t last, input serial_t cur);
    serial_t diff;
    diff = last - cur;
    return (diff != '0) && !diff[SERIAL_WIDTH-1];
  endfunction

endpackage

// File: rtl/wrr_rank_calc_pipe_state_ram.sv
// Per-class {epoch, round, credit} storage: sync-read pipeline port, sync-read CPU port, one write port.
// A read colliding with a write to the same address returns the old data; the caller bypasses.
module wrr_state_ram
  import wrr_pkg::*;
(
  input  logic                clk_dp,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] rd_addr,
  output state_t              rd_data,
  input  logic [ID_WIDTH-1:0] cpu_addr,
  output state_t              cpu_data,
  input  logic                wr_en,
  input  logic [ID_WIDTH-1:0] wr_addr,
  input  state_t              wr_data
);

  state_t mem [RAM_DEPTH];

  always_ff @(posedge clk_dp or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= '0;
      rd_data  <= '0;
      cpu_data <= '0;
    end else begin
      rd_data  <= (rd_addr < ID_WIDTH'(RAM_DEPTH)) ? mem[rd_addr] : '0;
      cpu_data <= (cpu_addr < ID_WIDTH'(RAM_DEPTH)) ? mem[cpu_addr] : '0;
      if (wr_en && (wr_addr < ID_WIDTH'(RAM_DEPTH))) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/wrr_rank_calc_pipe.sv
// Two-stage WRR rank calculator: S1 decodes the id and reads state, S2 updates credit/round
// and writes back; results appear two cycles after the request. CPU channel owns the weights.
module wrr_rank_calc_pipe
  import wrr_pkg::*;
(
  input  logic                              clk_dp,
  input  logic                              rst,
  input  logic                              tuple_in_my_pifo_rank_calc_input_VALID,
  input  logic [IN_DATA_WIDTH-1:0]          tuple_in_my_pifo_rank_calc_input_DATA,
  output logic                              tuple_out_my_pifo_rank_calc_output_VALID,
  output logic [RESULT_WIDTH-1:0]           tuple_out_my_pifo_rank_calc_output_DATA,
  input  logic [NUM_PORTS*RESULT_WIDTH-1:0] wire_in_last_pkt_info,
  input  logic                              wire_in_cpu_valid,
  input  logic                              wire_in_cpu_write_sig,
  input  logic                              wire_in_cpu_read_sig,
  input  logic [ID_WIDTH-1:0]               wire_in_cpu_index,
  input  logic [CREDIT_WIDTH-1:0]           wire_in_cpu_config_write,
  output logic                              wire_out_cpu_valid,
  output logic [ID_WIDTH-1:0]               wire_out_cpu_index,
  output logic [CPU_VAL_WIDTH-1:0]          wire_out_cpu_val
);

  logic [PORT_INFO_WIDTH-1:0] in_port_info;
  logic [CLASS_WIDTH-1:0]     in_class;
  logic [PORT_ID_WIDTH-1:0]   in_port_id;
  logic [ID_WIDTH-1:0]        in_id;
  result_t                    in_last;
  logic                       unused_last_fields;

  logic                    s2_valid;
  logic [ID_WIDTH-1:0]     s2_id;
  logic [CLASS_WIDTH-1:0]  s2_class;
  rank_t                   s2_last;

  logic                    wb_valid;
  logic [ID_WIDTH-1:0]     wb_id;
  state_t                  wb_state;

  state_t                  ram_rd_data, cpu_state;
  state_t                  cur_state, nxt_state;
  logic [CREDIT_WIDTH-1:0] weight;
  result_t                 result;

  logic [CREDIT_WIDTH-1:0] cfg [RAM_DEPTH];
  logic                    cpu_act_q;
  logic [ID_WIDTH-1:0]     cpu_index_q;
  logic [CREDIT_WIDTH-1:0] cpu_cfg_q;

  assign {in_port_info, in_class} = tuple_in_my_pifo_rank_calc_input_DATA;
  assign in_port_id = decode_port(in_port_info);
  assign in_id      = {in_port_id, in_class};

  always_comb begin
    in_last = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_port_id == PORT_ID_WIDTH'(p))
        in_last = wire_in_last_pkt_info[p*RESULT_WIDTH +: RESULT_WIDTH];
    end
  end

  assign unused_last_fields = ^{in_last.valid, in_last.cls, in_last.pifo_info};

  wrr_state_ram u_state_ram (
    .clk_dp   (clk_dp),
    .rst      (rst),
    .rd_addr  (in_id),
    .rd_data  (ram_rd_data),
    .cpu_addr (wire_in_cpu_index),
    .cpu_data (cpu_state),
    .wr_en    (s2_valid),
    .wr_addr  (s2_id),
    .wr_data  (nxt_state)
  );

  // The RAM read issued in S1 misses a write-back landing on the same edge, so forward it here.
  always_comb begin
    cur_state = (wb_valid && (wb_id == s2_id)) ? wb_state : ram_rd_data;
    weight    = cfg[s2_id];
    if (weight == '0) weight = CREDIT_WIDTH'(1);
    nxt_state = cur_state;
    if (is_stale(s2_last, cur_state.rank)) begin
      nxt_state.rank   = s2_last;
      nxt_state.credit = CREDIT_WIDTH'(1);
    end else if (cur_state.credit < weight) begin
      nxt_state.credit = cur_state.credit + CREDIT_WIDTH'(1);
    end else begin
      nxt_state.credit = CREDIT_WIDTH'(1);
      nxt_state.rank   = rank_t'(serial_t'(cur_state.rank) + SERIAL_WIDTH'(1));
    end
    result.valid     = 1'b1;
    result.cls       = s2_class;
    result.rank      = nxt_state.rank;
    result.pifo_info = '0;
  end

  always_ff @(posedge clk_dp or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_class <= '0;
      s2_last  <= '0;
      wb_valid <= 1'b0;
      wb_id    <= '0;
      wb_state <= '0;
      tuple_out_my_pifo_rank_calc_output_VALID <= 1'b0;
      tuple_out_my_pifo_rank_calc_output_DATA  <= '0;
    end else begin
      s2_valid <= tuple_in_my_pifo_rank_calc_input_VALID;
      s2_id    <= in_id;
      s2_class <= in_class;
      s2_last  <= in_last.rank;
      wb_valid <= s2_valid;
      wb_id    <= s2_id;
      wb_state <= nxt_state;
      tuple_out_my_pifo_rank_calc_output_VALID <= s2_valid;
      tuple_out_my_pifo_rank_calc_output_DATA  <= s2_valid ? RESULT_WIDTH'(result) : '0;
    end
  end

  // A write updates the weight at the edge, so a packet in S2 that cycle still sees the old one.
  always_ff @(posedge clk_dp or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) cfg[i] <= '0;
      wire_out_cpu_valid <= 1'b0;
      cpu_act_q          <= 1'b0;
      cpu_index_q        <= '0;
      cpu_cfg_q          <= '0;
    end else begin
      wire_out_cpu_valid <= wire_in_cpu_valid;
      cpu_act_q          <= wire_in_cpu_valid && (wire_in_cpu_write_sig || wire_in_cpu_read_sig);
      cpu_index_q        <= '0;
      cpu_cfg_q          <= '0;
      if (wire_in_cpu_valid && wire_in_cpu_write_sig) begin
        if (wire_in_cpu_index < ID_WIDTH'(RAM_DEPTH))
          cfg[wire_in_cpu_index] <= wire_in_cpu_config_write;
        cpu_index_q <= wire_in_cpu_index;
        cpu_cfg_q   <= wire_in_cpu_config_write;
      end else if (wire_in_cpu_valid && wire_in_cpu_read_sig) begin
        cpu_index_q <= wire_in_cpu_index;
        cpu_cfg_q   <= (wire_in_cpu_index < ID_WIDTH'(RAM_DEPTH)) ? cfg[wire_in_cpu_index] : '0;
      end
    end
  end

  assign wire_out_cpu_index = cpu_index_q;
  assign wire_out_cpu_val   = cpu_act_q ? {cpu_state.rank, cpu_cfg_q, cpu_state.credit} : '0;

endmodule

// File: tb/tb_wrr_rank_calc_pipe.sv
// Directed bench for wrr_rank_calc_pipe: stimulus pushes hand-computed results into queues,
// negedge monitors pop and compare whenever the DUT presents a result or CPU reply.
module tb_wrr_rank_calc_pipe;
  import wrr_pkg::*;

  logic                              clk_dp;
  logic                              rst;
  logic                              in_valid;
  logic [IN_DATA_WIDTH-1:0]          in_data;
  logic                              out_valid;
  logic [RESULT_WIDTH-1:0]           out_data;
  logic [NUM_PORTS*RESULT_WIDTH-1:0] last_info;
  logic                              cpu_valid, cpu_write, cpu_read;
  logic [ID_WIDTH-1:0]               cpu_index;
  logic [CREDIT_WIDTH-1:0]           cpu_cfg;
  logic                              cpu_out_valid;
  logic [ID_WIDTH-1:0]               cpu_out_index;
  logic [CPU_VAL_WIDTH-1:0]          cpu_out_val;

  int checks = 0;
  int errors = 0;

  logic [RESULT_WIDTH-1:0]          exp_q [$];
  logic [ID_WIDTH+CPU_VAL_WIDTH-1:0] cpu_q [$];
  logic [RESULT_WIDTH-1:0]          mon_exp;
  logic [ID_WIDTH+CPU_VAL_WIDTH-1:0] mon_cpu_exp;

  wrr_rank_calc_pipe dut (
    .clk_dp                                   (clk_dp),
    .rst                                      (rst),
    .tuple_in_my_pifo_rank_calc_input_VALID   (in_valid),
    .tuple_in_my_pifo_rank_calc_input_DATA    (in_data),
    .tuple_out_my_pifo_rank_calc_output_VALID (out_valid),
    .tuple_out_my_pifo_rank_calc_output_DATA  (out_data),
    .wire_in_last_pkt_info                    (last_info),
    .wire_in_cpu_valid                        (cpu_valid),
    .wire_in_cpu_write_sig                    (cpu_write),
    .wire_in_cpu_read_sig                     (cpu_read),
    .wire_in_cpu_index                        (cpu_index),
    .wire_in_cpu_config_write                 (cpu_cfg),
    .wire_out_cpu_valid                       (cpu_out_valid),
    .wire_out_cpu_index                       (cpu_out_index),
    .wire_out_cpu_val                         (cpu_out_val)
  );

  initial clk_dp = 1'b0;
  always #5 clk_dp = ~clk_dp;

  function automatic logic [RESULT_WIDTH-1:0] mk_result(input logic [CLASS_WIDTH-1:0] cls,
                                                        input logic [SERIAL_WIDTH-1:0] serial);
    return {1'b1, cls, serial, {PIFO_INFO_WIDTH{1'b0}}};
  endfunction

  function automatic logic [CPU_VAL_WIDTH-1:0] cpu_val(input logic [SERIAL_WIDTH-1:0] serial,
                                                      input logic [CREDIT_WIDTH-1:0] cfg,
                                                      input logic [CREDIT_WIDTH-1:0] credit);
    return {serial, cfg, credit};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every call presents one packet for one cycle; last_info is replicated into every port slot.
  task automatic applyStimulus(input logic [PORT_INFO_WIDTH-1:0] port, input logic [CLASS_WIDTH-1:0] cls,
                               input logic [SERIAL_WIDTH-1:0] last, input logic [SERIAL_WIDTH-1:0] exp_serial,
                               input bit expect_out);
    @(posedge clk_dp); #1;
    in_valid  = 1'b1;
    in_data   = {port, cls};
    last_info = {NUM_PORTS{mk_result('0, last)}};
    if (expect_out) exp_q.push_back(mk_result(cls, exp_serial));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_dp); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic cpuOp(input bit wr, input bit rd, input logic [ID_WIDTH-1:0] idx,
                       input logic [CREDIT_WIDTH-1:0] data, input logic [CPU_VAL_WIDTH-1:0] exp_val);
    @(posedge clk_dp); #1;
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_read  = rd;
    cpu_index = idx;
    cpu_cfg   = data;
    cpu_q.push_back({idx, exp_val});
    @(posedge clk_dp); #1;
    cpu_valid = 1'b0;
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
  endtask

  always @(negedge clk_dp) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got %h expected no result at %0t", out_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("rank_result", 64'(out_data), 64'(mon_exp));
      end
    end else begin
      checkOutput("idle_result_data", 64'(out_data), 64'd0);
    end
    if (cpu_out_valid) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_cpu_reply: got %h expected no reply at %0t", cpu_out_val, $time);
      end else begin
        mon_cpu_exp = cpu_q.pop_front();
        checkOutput("cpu_reply", 64'({cpu_out_index, cpu_out_val}), 64'(mon_cpu_exp));
      end
    end else begin
      checkOutput("idle_cpu_reply", 64'({cpu_out_index, cpu_out_val}), 64'd0);
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    last_info = '0;
    cpu_valid = 1'b0;
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    cpu_index = '0;
    cpu_cfg   = '0;
    repeat (3) @(negedge clk_dp);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_cpu_valid", 64'(cpu_out_valid), 64'd0);
    @(posedge clk_dp); #1;
    rst = 1'b0;

    $display("[TB] weight 3 credit/round sequence");
    cpuOp(1'b1, 1'b0, 8'h02, 8'd3, cpu_val(13'd0, 8'd3, 8'd0));
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd0, 1'b1);
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd0, 1'b1);
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd0, 1'b1);
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd1, 1'b1);
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd1, 1'b1);
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd1, 1'b1);
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd2, 1'b1);
    idle(3);
    cpuOp(1'b0, 1'b1, 8'h02, 8'd0, cpu_val(13'd2, 8'd3, 8'd1));

    $display("[TB] back-to-back vs spaced packets");
    cpuOp(1'b1, 1'b0, 8'h03, 8'd2, cpu_val(13'd0, 8'd2, 8'd0));
    cpuOp(1'b1, 1'b0, 8'h04, 8'd2, cpu_val(13'd0, 8'd2, 8'd0));
    applyStimulus(8'h01, 5'd3, 13'd0, 13'd0, 1'b1);
    applyStimulus(8'h01, 5'd3, 13'd0, 13'd0, 1'b1);
    applyStimulus(8'h01, 5'd3, 13'd0, 13'd1, 1'b1);
    applyStimulus(8'h01, 5'd3, 13'd0, 13'd1, 1'b1);
    applyStimulus(8'h01, 5'd3, 13'd0, 13'd2, 1'b1);
    applyStimulus(8'h01, 5'd3, 13'd0, 13'd2, 1'b1);
    idle(1);
    applyStimulus(8'h01, 5'd4, 13'd0, 13'd0, 1'b1); idle(3);
    applyStimulus(8'h01, 5'd4, 13'd0, 13'd0, 1'b1); idle(3);
    applyStimulus(8'h01, 5'd4, 13'd0, 13'd1, 1'b1); idle(3);
    applyStimulus(8'h01, 5'd4, 13'd0, 13'd1, 1'b1); idle(3);
    applyStimulus(8'h01, 5'd4, 13'd0, 13'd2, 1'b1); idle(3);
    applyStimulus(8'h01, 5'd4, 13'd0, 13'd2, 1'b1); idle(3);
    cpuOp(1'b0, 1'b1, 8'h03, 8'd0, cpu_val(13'd2, 8'd2, 8'd2));

    $display("[TB] resync to last dequeued rank");
    applyStimulus(8'h01, 5'd5, 13'd10, 13'd10, 1'b1);
    applyStimulus(8'h01, 5'd5, 13'd50, 13'd50, 1'b1);
    applyStimulus(8'h01, 5'd5, 13'd5,  13'd51, 1'b1);
    idle(3);
    cpuOp(1'b0, 1'b1, 8'h05, 8'd0, cpu_val(13'd51, 8'd0, 8'd1));

    $display("[TB] round and epoch wraparound");
    cpuOp(1'b1, 1'b0, 8'h06, 8'd1, cpu_val(13'd0, 8'd1, 8'd0));
    applyStimulus(8'h01, 5'd6, 13'd2047, 13'd2047, 1'b1);
    applyStimulus(8'h01, 5'd6, 13'd0,    13'd2048, 1'b1);
    applyStimulus(8'h01, 5'd6, 13'd6143, 13'd6143, 1'b1);
    applyStimulus(8'h01, 5'd6, 13'd8191, 13'd8191, 1'b1);
    applyStimulus(8'h01, 5'd6, 13'd8191, 13'd0,    1'b1);
    applyStimulus(8'h01, 5'd6, 13'd4000, 13'd4000, 1'b1);
    applyStimulus(8'h01, 5'd6, 13'd8000, 13'd8000, 1'b1);
    applyStimulus(8'h01, 5'd6, 13'd8184, 13'd8184, 1'b1);
    applyStimulus(8'h01, 5'd6, 13'd3,    13'd3,    1'b1);
    idle(3);
    cpuOp(1'b0, 1'b1, 8'h06, 8'd0, cpu_val(13'd3, 8'd1, 8'd1));

    $display("[TB] port decode and CPU readback");
    applyStimulus(8'h02, 5'd7, 13'd0, 13'd0, 1'b1);
    applyStimulus(8'h00, 5'd7, 13'd0, 13'd1, 1'b1);
    applyStimulus(8'h05, 5'd7, 13'd0, 13'd2, 1'b1);
    applyStimulus(8'h10, 5'd7, 13'd0, 13'd0, 1'b1);
    idle(3);
    cpuOp(1'b0, 1'b1, 8'h87, 8'd0, cpu_val(13'd2, 8'd0, 8'd1));
    cpuOp(1'b1, 1'b1, 8'h87, 8'd5, cpu_val(13'd2, 8'd5, 8'd1));
    cpuOp(1'b0, 1'b1, 8'h47, 8'd0, cpu_val(13'd0, 8'd0, 8'd1));
    cpuOp(1'b0, 1'b1, 8'h07, 8'd0, cpu_val(13'd0, 8'd0, 8'd0));

    $display("[TB] reset with a packet in flight");
    idle(3);
    applyStimulus(8'h01, 5'd9, 13'd0, 13'd0, 1'b0);
    @(posedge clk_dp); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk_dp);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_data", 64'(out_data), 64'd0);
    checkOutput("midreset_cpu", 64'({cpu_out_valid, cpu_out_index, cpu_out_val}), 64'd0);
    @(posedge clk_dp); #1;
    rst = 1'b0;
    cpuOp(1'b0, 1'b1, 8'h02, 8'd0, cpu_val(13'd0, 8'd0, 8'd0));
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd0, 1'b1);
    applyStimulus(8'h01, 5'd2, 13'd0, 13'd1, 1'b1);
    idle(1);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || cpu_q.size() != 0); i++) @(posedge clk_dp);
    @(negedge clk_dp);
    checkOutput("queues_drained", 64'(exp_q.size() + cpu_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
